// File: rtl/gf2m_pkg.sv
// Shared types and constants for the GF(2^M) multiplier family.
package gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] GF16_POLY  = 5'h13;
    localparam logic [8:0] GF256_POLY = 9'h11B;

    // Number of BUSY cycles needed to consume all of operand b.
    function automatic int digit_count(input int m, input int d);
        return m / d;
    endfunction

endpackage

// File: rtl/gf2m_mul_seq_if.sv
// Operand/result handshake bundle for gf2m_mul_seq.
// The addend in_c exists only when GF2M_MUL_MAC_EN is defined.
interface gf2m_mul_seq_if #(
    parameter int M = 8
);

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
`ifdef GF2M_MUL_MAC_EN
    logic [M-1:0] in_c;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_r;

`ifdef GF2M_MUL_MAC_EN
    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_r
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_r
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r
    );
`endif

endinterface

// File: rtl/gf2m_digit_step.sv
// One BUSY cycle of the Horner multiplier: DIGIT chained xtime/XOR stages,
// consuming b_i from its MSB down.
module gf2m_digit_step #(
    parameter int M     = 8,
    parameter int DIGIT = 1
) (
    input  logic [M-1:0]     r_i,
    input  logic [M-1:0]     a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic [M-1:0]     poly_i,
    output logic [M-1:0]     r_o
);

    logic [M-1:0] acc;

    always_comb begin
        acc = r_i;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? poly_i : '0) ^ (b_i[i] ? a_i : '0);
        end
        r_o = acc;
    end

endmodule

// File: rtl/gf2m_mul_seq.sv
// Digit-serial GF(2^M) multiplier with valid/ready handshake on both sides.
// Defining GF2M_MUL_MAC_EN adds an addend c, giving a*b ^ c.
module gf2m_mul_seq
    import gf2m_pkg::*;
#(
    parameter int           M     = 8,
    parameter logic [M:0]   POLY  = (M+1)'(GF256_POLY),
    parameter int           DIGIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    gf2m_mul_seq_if.slave  bus
);

    localparam int           NDIG = digit_count(M, DIGIT);
    localparam int           CW   = $clog2(NDIG + 1);
    localparam logic [M-1:0] RED  = POLY[M-1:0];

    if (M < 2 || M > 32) begin : g_bad_width
        $error("gf2m_mul_seq: M must lie in 2..32");
    end
    if (DIGIT < 1 || (M % DIGIT) != 0) begin : g_bad_digit
        $error("gf2m_mul_seq: DIGIT must divide M");
    end

    state_e        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  r_q, r_d;
    logic [M-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  stepR;
    logic [M-1:0]  finalR;
    logic          inReady;
    logic          loadOperands;

    gf2m_digit_step #(
        .M     (M),
        .DIGIT (DIGIT)
    ) u_step (
        .r_i    (r_q),
        .a_i    (a_q),
        .b_i    (b_q[M-1 -: DIGIT]),
        .poly_i (RED),
        .r_o    (stepR)
    );

`ifdef GF2M_MUL_MAC_EN
    logic [M-1:0] c_q, c_d;
    assign finalR = stepR ^ c_q;
`else
    assign finalR = stepR;
`endif

    // A result sitting in DONE frees the unit in the same cycle it is taken.
    assign inReady       = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_r     = out_q;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        r_d          = r_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
`ifdef GF2M_MUL_MAC_EN
        c_d          = c_q;
`endif
        loadOperands = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    loadOperands = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(NDIG - 1)) begin
                    out_d   = finalR;
                    state_d = DONE;
                end else begin
                    r_d   = stepR;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        loadOperands = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (loadOperands) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            r_d     = '0;
            cnt_d   = '0;
`ifdef GF2M_MUL_MAC_EN
            c_d     = bus.in_c;
`endif
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
`ifdef GF2M_MUL_MAC_EN
            c_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef GF2M_MUL_MAC_EN
            c_q     <= c_d;
`endif
        end
    end

endmodule

// File: tb/tb_gf2m_mul_seq.sv
// Self-checking bench for gf2m_mul_seq: directed GF(2^8)/GF(2^4) vectors,
// backpressure, mid-operation reset and randomised streams for DIGIT 1/2/4/8.
module tb_gf2m_mul_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic startRand = 1'b0;
    int   randDone  = 0;

    always #5 clk = ~clk;

    gf2m_mul_seq_if #(.M(8)) b8();
    gf2m_mul_seq_if #(.M(4)) b4();

    gf2m_mul_seq #(.M(8), .POLY(9'h11B), .DIGIT(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    gf2m_mul_seq #(.M(4), .POLY(gf2m_pkg::GF16_POLY), .DIGIT(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    // Reference GF(2^8) multiply, LSB-first shift-and-add with AES reduction.
    function automatic logic [7:0] gfMul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output int lat);
        int guard;
        @(posedge clk); #1;
        b8.in_a = a; b8.in_b = b; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        guard = 0;
        while (!b8.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.in_a = 8'hA5; b8.in_b = 8'h5A;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        r = b8.out_r;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] r, output int lat);
        int guard;
        @(posedge clk); #1;
        b4.in_a = a; b4.in_b = b; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
        guard = 0;
        while (!b4.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        b4.in_valid = 1'b0; b4.in_a = 4'h6; b4.in_b = 4'h9;
        lat = 0;
        while (!b4.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        r = b4.out_r;
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid8: got %b expected 0", b8.out_valid); end
        checks++; if (b8.out_r !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_r8: got %h expected 00", b8.out_r); end
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready8: got %b expected 1", b8.in_ready); end
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid4: got %b expected 0", b4.out_valid); end
        checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready4: got %b expected 1", b4.in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_gf256();
        logic [7:0] r;
        int lat;
        run8(8'h57, 8'h83, r, lat);
        checks++; if (r !== 8'hC1) begin errors++; $display("[TB] FAIL gf256_57x83: got %h expected c1", r); end
        checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL gf256_latency: got %0d expected 8", lat); end
        run8(8'h57, 8'h13, r, lat);
        checks++; if (r !== 8'hFE) begin errors++; $display("[TB] FAIL gf256_57x13: got %h expected fe", r); end
        run8(8'h00, 8'hAB, r, lat);
        checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL gf256_zero: got %h expected 00", r); end
    endtask

    task automatic test_gf16();
        logic [3:0] r;
        int lat;
        run4(4'h2, 4'h9, r, lat);
        checks++; if (r !== 4'h1) begin errors++; $display("[TB] FAIL gf16_2x9: got %h expected 1", r); end
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL gf16_latency: got %0d expected 2", lat); end
        run4(4'hF, 4'h1, r, lat);
        checks++; if (r !== 4'hF) begin errors++; $display("[TB] FAIL gf16_Fx1: got %h expected f", r); end
        run4(4'h0, 4'hB, r, lat);
        checks++; if (r !== 4'h0) begin errors++; $display("[TB] FAIL gf16_0xB: got %h expected 0", r); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(posedge clk); #1;
        b8.in_a = 8'h57; b8.in_b = 8'h83; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep offering the next pair throughout BUSY; it must only land after DONE is consumed.
        b8.in_a = 8'h57; b8.in_b = 8'h13;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (b8.out_r !== 8'hC1) begin errors++; $display("[TB] FAIL bp_first_result: got %h expected c1", b8.out_r); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (b8.out_valid !== 1'b1 || b8.out_r !== 8'hC1) begin errors++; $display("[TB] FAIL bp_hold_%0d: got valid=%b r=%h expected valid=1 r=c1", i, b8.out_valid, b8.out_r); end
            checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_%0d: got %b expected 0", i, b8.in_ready); end
        end
        b8.out_ready = 1'b1;
        #1;
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_release: got %b expected 1", b8.in_ready); end
        @(posedge clk); #1;
        b8.out_ready = 1'b0; b8.in_valid = 1'b0;
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_b2b_busy: got valid=%b expected 0", b8.out_valid); end
        lat = 0;
        while (!b8.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat !== 8 || b8.out_r !== 8'hFE) begin errors++; $display("[TB] FAIL bp_b2b_result: got r=%h lat=%0d expected r=fe lat=8", b8.out_r, lat); end
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] r;
        int lat;
        @(posedge clk); #1;
        b8.in_a = 8'h0F; b8.in_b = 8'hF0; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", b8.out_valid); end
        checks++; if (b8.out_r !== 8'h00) begin errors++; $display("[TB] FAIL midrst_out_r: got %h expected 00", b8.out_r); end
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", b8.in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        run8(8'h57, 8'h83, r, lat);
        checks++; if (r !== 8'hC1 || lat !== 8) begin errors++; $display("[TB] FAIL midrst_next: got r=%h lat=%0d expected r=c1 lat=8", r, lat); end
    endtask

`ifdef GF2M_MUL_MAC_EN
    task automatic test_mac();
        logic [7:0] r;
        int lat;
        b8.in_c = 8'h3C;
        run8(8'h57, 8'h83, r, lat);
        b8.in_c = 8'h00;
        checks++; if (r !== 8'hFD || lat !== 8) begin errors++; $display("[TB] FAIL mac_57x83_3c: got r=%h lat=%0d expected r=fd lat=8", r, lat); end
    endtask
`endif

    task automatic test_random_streams();
        int guard;
        startRand = 1'b1;
        guard = 0;
        while (randDone < 4 && guard < 20000) begin
            @(posedge clk); guard++;
        end
        checks++; if (randDone !== 4) begin errors++; $display("[TB] FAIL rand_completion: got %0d streams done expected 4", randDone); end
    endtask

    // One randomised producer/consumer stream per digit size, checked in order.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int DG = 1 << g;

        gf2m_mul_seq_if #(.M(8)) rb();

        gf2m_mul_seq #(.M(8), .POLY(9'h11B), .DIGIT(DG)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (rb)
        );

        initial begin
            logic [7:0] expQueue[$];
            logic [7:0] expVal;
            int sent;
            int recv;
            int cyc;
            logic took;
            rb.in_valid = 1'b0; rb.out_ready = 1'b0; rb.in_a = 8'h00; rb.in_b = 8'h00;
`ifdef GF2M_MUL_MAC_EN
            rb.in_c = 8'h00;
`endif
            wait (startRand);
            sent = 0; recv = 0; cyc = 0; took = 1'b0;
            while (recv < 24 && cyc < 4000) begin
                @(posedge clk); #1;
                cyc++;
                if (took) rb.in_valid = 1'b0;
                took = 1'b0;
                if (!rb.in_valid && sent < 24 && $urandom_range(0, 3) != 0) begin
                    rb.in_a = 8'($urandom); rb.in_b = 8'($urandom); rb.in_valid = 1'b1;
                end
                rb.out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (rb.out_valid && rb.out_ready) begin
                    checks++;
                    if (expQueue.size() == 0) begin
                        errors++; $display("[TB] FAIL rand_d%0d_extra: got result %h expected none pending", DG, rb.out_r);
                    end else begin
                        expVal = expQueue.pop_front();
                        if (rb.out_r !== expVal) begin errors++; $display("[TB] FAIL rand_d%0d_result: got %h expected %h", DG, rb.out_r, expVal); end
                    end
                    recv++;
                end
                if (rb.in_valid && rb.in_ready) begin
                    expQueue.push_back(gfMul8(rb.in_a, rb.in_b));
                    sent++;
                    took = 1'b1;
                end
            end
            @(posedge clk); #1;
            rb.in_valid = 1'b0; rb.out_ready = 1'b0;
            checks++; if (sent !== 24 || recv !== 24 || expQueue.size() != 0) begin errors++; $display("[TB] FAIL rand_d%0d_count: got sent=%0d recv=%0d pending=%0d expected 24/24/0", DG, sent, recv, expQueue.size()); end
            randDone++;
        end
    end

    initial begin
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.in_a = 8'h00; b8.in_b = 8'h00;
        b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.in_a = 4'h0; b4.in_b = 4'h0;
`ifdef GF2M_MUL_MAC_EN
        b8.in_c = 8'h00;
        b4.in_c = 4'h0;
`endif
        test_reset();
        test_gf256();
        test_gf16();
        test_backpressure();
        test_reset_mid_busy();
`ifdef GF2M_MUL_MAC_EN
        test_mac();
`endif
        test_random_streams();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf2m_mul_seq.md
# gf2m_mul_seq

Sequential digit-serial multiplier over GF(2^M), with field width, reduction polynomial and digit size set by parameters. It generalises the fixed-field GF(16) combinational multiplier into a handshaked, multi-cycle unit that trades latency for area. It sits in the datapath beside the finite-field arithmetic blocks (syndrome and checksum engines) and accepts one operand pair per transaction through a valid/ready interface.

## Interface
- `M`, default 8: field width in bits; legal range 2..32.
- `POLY`, default `'h11B`: reduction polynomial, M+1 bits, bit M set; only bits M-1..0 are used internally.
- `DIGIT`, default 1: operand-b bits consumed per cycle; M % DIGIT must equal 0, else elaboration error.
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept an operand pair.
- `in_a` input M: multiplicand.
- `in_b` input M: multiplier.
- `in_c` input M: addend; present only with `GF2M_MUL_MAC_EN`.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `out_r` output M: product, reduced modulo POLY.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE; `out_r` = 0, `out_valid` = 0, `in_ready` = 1, and the internal registers clear to 0.
- Accept occurs when `in_valid` && `in_ready`. On accept, `in_a` and `in_b` are registered, the accumulator r is set to 0, and the digit counter is set to 0. The FSM goes to BUSY.
- BUSY: process b MSB-first (Horner form). Each cycle applies DIGIT inner steps: r = xtime(r) ^ (b_bit ? a : 0).
  - xtime(r) = (r << 1)[M-1:0] ^ (r[M-1] ? POLY[M-1:0] : 0).
  - After each cycle, b shifts left by DIGIT and the counter increments.
- When the counter reaches M/DIGIT - 1, the final digit's result loads into `out_r` and the FSM goes to DONE.
- DONE: `out_valid` = 1. `out_r` is held stable until `out_ready` is seen.
- DONE with `out_ready` = 1: the result is consumed this cycle.
  - If `in_valid` is also high, the new operands are accepted in the same cycle and the FSM goes to BUSY (back-to-back operation).
  - Otherwise the FSM goes to IDLE.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready). It is a combinational function of state and `out_ready`.
- Inputs are ignored while BUSY. `in_a`/`in_b` may change freely after acceptance.
- Operand values of 0 need no special path: they yield 0 through the normal iteration.
- Asserting `reset` in any state aborts the operation immediately. A partial result is never presented.

## Timing
- Latency: an accept at edge T gives `out_valid` high after edge T + M/DIGIT.
- Throughput: one result per M/DIGIT + 1 cycles if the consumer stalls zero cycles. With the back-to-back accept in DONE, it is one result per M/DIGIT cycles plus the DONE cycle.
- With M=8 and DIGIT=1: 8 BUSY cycles, then DONE.
- With M=8 and DIGIT=4: 2 BUSY cycles, then DONE.
- The critical path is DIGIT chained xtime/XOR stages. DIGIT = M gives a single BUSY cycle.

## Configuration
- `GF2M_MUL_MAC_EN` defined: the `in_c` port exists and is registered on accept. The result is a·b ^ c, with c XORed in on the final digit cycle. Latency is unchanged.
- `GF2M_MUL_MAC_EN` undefined: there is no `in_c` port and the result is a·b.

## Structure
- Shared package `gf2m_pkg`:
  - state enum (IDLE, BUSY, DONE)
  - constant function for the digit count M/DIGIT
  - default polynomial constants: GF16 `'h13`, GF256 `'h11B`
- One sub-module, `gf2m_digit_step`: a combinational block taking r, a, a DIGIT-bit b slice and POLY, and returning the updated r. It is instantiated once.

## Test plan
- Default parameters (M=8, POLY=`'h11B`, DIGIT=1): a=0x57, b=0x83 -> `out_r`=0xC1 after 8 BUSY cycles. a=0x57, b=0x13 -> 0xFE.
- M=4, POLY=`'h13`, DIGIT=2: a=0x2, b=0x9 -> 0x1. a=0xF, b=0x1 -> 0xF. a=0x0, b=0xB -> 0x0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. `out_r` must stay stable, and `in_ready` must stay 0. Pulsing `out_ready` with `in_valid` high must then accept new operands in the same cycle.
- Reset mid-BUSY (cycle 3 of 8): `out_valid`=0, `out_r`=0 and `in_ready`=1 immediately. The next transaction, 0x57·0x83, gives 0xC1.
- `GF2M_MUL_MAC_EN` with c=0x3C: 0x57·0x83 ^ 0x3C = 0xFD.
- Randomised streams (random stalls) for DIGIT ∈ {1,2,4,8} checked against a software GF(2^8) model, with no result dropped or duplicated.
